// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port.
// Holds the access-size encodings, the FSM state encoding and the alignment helpers.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // True when the byte offset is illegal for the (normalised) access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  // Offset after forcing natural alignment for the access size.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between 32-bit memory words and RV32I sub-word accesses.
// Ports:
//   i_rd       word read from memory
//   i_off      byte offset inside the word (already naturally aligned)
//   i_size     access size (SZ_BYTE / SZ_HALF / word)
//   i_unsigned zero-extend loads instead of sign-extend
//   i_wdata    right-aligned store data
//   o_ld_data  extracted and extended load result
//   o_st_data  i_rd with the store data merged into the addressed lane(s)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_data
);

  logic [31:0] w_shift;
  logic [31:0] w_mask;
  logic [31:0] w_rep;

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shift   = i_rd >> {i_off, 3'b000};
    o_ld_data = i_rd;
    case (i_size)
      SZ_BYTE: o_ld_data = i_unsigned ? {24'h000000, w_shift[7:0]}
                                      : {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: o_ld_data = i_unsigned ? {16'h0000, w_shift[15:0]}
                                      : {{16{w_shift[15]}}, w_shift[15:0]};
      default: o_ld_data = i_rd;
    endcase
  end

  // Store path: replicate the data across lanes and splice it in under a lane mask.
  always_comb begin
    w_mask    = 32'hFFFF_FFFF;
    w_rep     = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        w_mask = 32'h0000_00FF << {i_off, 3'b000};
        w_rep  = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_mask = 32'h0000_FFFF << {i_off[1], 4'b0000};
        w_rep  = {2{i_wdata[15:0]}};
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_rep  = i_wdata;
      end
    endcase
    o_st_data = (i_rd & ~w_mask) | (w_rep & w_mask);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator driving a single-port, word-wide BRAM with registered read data.
// Sub-word stores are done as read-modify-write; one request in flight at a time.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned requests return resp_err without
// touching memory; when undefined, misaligned addresses are force-aligned and resp_err is 0.
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_we/size/unsigned/addr/wdata  latched request fields
//   resp_valid/rdata/err        one-cycle completion pulse with load data / error flag
//   mem_a/mem_wd/mem_we/mem_rd  memory port
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter  int unsigned N  = 1024,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  input  logic [31:0]   mem_rd
);

  state_t        r_state;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [1:0]    r_off;
  logic [31:0]   r_wdata;
  logic [AW-1:0] r_mem_a;
  logic [31:0]   r_mem_wd;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;

  logic          w_hs;
  logic [1:0]    w_size_n;
  logic          w_word_st;
  logic          w_trap;
  logic [1:0]    w_off_eff;
  logic [31:0]   w_ld_data;
  logic [31:0]   w_st_merged;
  logic          w_unused;

  // Size 2'b11 behaves exactly like a word access.
  assign w_size_n  = req_size[1] ? SZ_WORD : req_size;
  assign w_hs      = req_valid && (r_state == ST_IDLE);
  assign w_word_st = req_we && (w_size_n == SZ_WORD);

`ifdef MISALIGN_TRAP_EN
  assign w_trap    = is_misaligned(w_size_n, req_addr[1:0]);
  assign w_off_eff = req_addr[1:0];
`else
  assign w_trap    = 1'b0;
  assign w_off_eff = align_off(w_size_n, req_addr[1:0]);
`endif

  // Address bits above the memory depth are don't-care.
  assign w_unused = ^req_addr[31:AW+2];

  lsu_lane_align u_align (
    .i_rd       (mem_rd),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_ld_data  (w_ld_data),
    .o_st_data  (w_st_merged)
  );

  // Request FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_uns        <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= 32'h0;
      r_mem_a      <= '0;
      r_mem_wd     <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_we    <= req_we;
            r_size  <= w_size_n;
            r_uns   <= req_unsigned;
            r_off   <= w_off_eff;
            r_wdata <= req_wdata;
            r_mem_a <= req_addr[AW+1:2];
            if (w_trap) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else if (w_word_st) begin
              r_state  <= ST_WRITE;
              r_mem_wd <= req_wdata;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: r_state <= ST_WAIT;
        // mem_rd now reflects the word addressed during READ.
        ST_WAIT: begin
          if (r_we) begin
            r_mem_wd <= w_st_merged;
            r_state  <= ST_WRITE;
          end else begin
            r_resp_rdata <= w_ld_data;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_resp_rdata <= 32'h0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign mem_we     = (r_state == ST_WRITE);
  assign mem_a      = r_mem_a;
  assign mem_wd     = r_mem_wd;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port with a behavioural BRAM model.
module tb_lsu_mem_port;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int resp_cnt = 0;
  int hs_cnt   = 0;
  int busy_cnt = 0;
  logic [9:0]  last_we_a;
  logic [31:0] last_we_d;
  logic [31:0] resp_q[$];

  lsu_mem_port dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .mem_rd       (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM: registered read, write on mem_we.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    mem_rd <= mem[mem_a];
  end

  // Activity monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt    <= we_cnt + 1;
      last_we_a <= mem_a;
      last_we_d <= mem_wd;
    end
    if (resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      resp_q.push_back(resp_rdata);
    end
    if (!rst && req_valid && req_ready)  hs_cnt   <= hs_cnt + 1;
    if (!rst && req_valid && !req_ready) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, measure handshake-to-resp_valid latency and check the response.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    bit found;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk_eq({tag, "_rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after the handshake; the DUT must use the latched copy.
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_size = ~sz; req_unsigned = ~uns;
    lat = 0; found = 1'b0;
    while (!found && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk_eq({tag, "_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) found = 1'b1;
    end
    chk_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk_eq({tag, "_rdata"}, resp_rdata, exp_rd);
    chk_eq({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    @(negedge clk);
    chk_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int we0;
    int r0;
    int h0;
    int b0;
    int k;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_eq("rst_ready", 32'(req_ready), 32'd1);
    chk_eq("rst_resp", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
    chk_eq("rst_rdata", resp_rdata, 32'h0);
    chk_eq("rst_mem_a", 32'(mem_a), 32'd0);
    chk_eq("rst_mem_wd", mem_wd, 32'h0);
    rst = 1'b0;

    // Word store then word load.
    we0 = we_cnt;
    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    chk_eq("sw10_wecnt", 32'(we_cnt - we0), 32'd1);
    chk_eq("sw10_wea", 32'(last_we_a), 32'd4);
    chk_eq("sw10_mem", mem[4], 32'hDEADBEEF);
    do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    // Byte store read-modify-write.
    do_req("sw10b", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0);
    we0 = we_cnt;
    do_req("sb12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 4, 32'h0, 1'b0);
    chk_eq("sb12_wecnt", 32'(we_cnt - we0), 32'd1);
    chk_eq("sb12_mem", mem[4], 32'h11AA3344);

    // Sub-word loads with sign/zero extension; size 2'b11 acts as word.
    do_req("sw14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h80FF7F01, 2, 32'h0, 1'b0);
    do_req("lb17", 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 3, 32'hFFFFFF80, 1'b0);
    do_req("lbu17", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 3, 32'h00000080, 1'b0);
    do_req("lh14", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 3, 32'h00007F01, 1'b0);
    do_req("lhu16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 3, 32'h000080FF, 1'b0);
    do_req("lh16s", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 3, 32'hFFFF80FF, 1'b0);
    do_req("lw11", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 3, 32'h80FF7F01, 1'b0);

    // Halfword store into the upper half.
    do_req("sh16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 4, 32'h0, 1'b0);
    chk_eq("sh16_mem", mem[5], 32'hBEEF7F01);

    // Misaligned accesses.
    we0 = we_cnt;
`ifdef MISALIGN_TRAP_EN
    do_req("sh15", 1'b1, 2'b01, 1'b0, 32'h15, 32'h00001234, 1, 32'h0, 1'b1);
    chk_eq("sh15_wecnt", 32'(we_cnt - we0), 32'd0);
    chk_eq("sh15_mem", mem[5], 32'hBEEF7F01);
    do_req("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
`else
    do_req("sh15", 1'b1, 2'b01, 1'b0, 32'h15, 32'h00001234, 4, 32'h0, 1'b0);
    chk_eq("sh15_wecnt", 32'(we_cnt - we0), 32'd1);
    chk_eq("sh15_mem", mem[5], 32'hBEEF1234);
    do_req("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 3, 32'h11AA3344, 1'b0);
`endif

    // Reset during the READ cycle of a byte store.
    do_req("sw18", 1'b1, 2'b10, 1'b0, 32'h18, 32'h55667788, 2, 32'h0, 1'b0);
    we0 = we_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h19; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_eq("rstmid_we", 32'(mem_we), 32'd0);
    chk_eq("rstmid_mem_a", 32'(mem_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rstmid_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk_eq("rstmid_wecnt", 32'(we_cnt - we0), 32'd0);
    chk_eq("rstmid_resp", 32'(resp_cnt - r0), 32'd0);
    chk_eq("rstmid_mem", mem[6], 32'h55667788);
    do_req("lw18", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 3, 32'h55667788, 1'b0);

    // Back-to-back alternating SW/LW with req_valid held high.
    @(posedge clk); #1;
    h0 = hs_cnt; r0 = resp_cnt; b0 = busy_cnt;
    resp_q.delete();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = (i % 2 == 0); req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'hC0DE0000 + 32'(i);
      k = 0;
      while (!req_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k == 20) chk_eq("b2b_ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    k = 0;
    while ((resp_cnt - r0) < 6 && k < 30) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk_eq("b2b_hs", 32'(hs_cnt - h0), 32'd6);
    chk_eq("b2b_resp", 32'(resp_cnt - r0), 32'd6);
    chk_eq("b2b_busy", 32'(busy_cnt - b0), 32'd12);
    chk_eq("b2b_st0", resp_q[0], 32'h0);
    chk_eq("b2b_ld1", resp_q[1], 32'hC0DE0000);
    chk_eq("b2b_ld3", resp_q[3], 32'hC0DE0002);
    chk_eq("b2b_ld5", resp_q[5], 32'hC0DE0004);
    chk_eq("b2b_mem", mem[8], 32'hC0DE0004);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives the single-port word-wide data memory (BRAM, one address, one write-data, one write-enable, registered read-data) on behalf of the execute stage.
- Converts RV32I byte, halfword and word loads/stores into word accesses.
- Loads: little-endian extraction plus sign or zero extension.
- Sub-word stores: read-modify-write, because the memory has no byte enables.
- One request in flight; single-pulse completion back to the pipeline.

Parameters:
N, 1024, data memory depth in 32-bit words
AW, $clog2(N), memory word-address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block idle, accepts request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for stores/words
req_addr  in  32  byte address; bits [AW+1:2] select the word, higher bits ignored
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned access (valid with resp_valid)
mem_a  out  AW  memory word address
mem_wd  out  32  memory write data
mem_we  out  1  memory write enable
mem_rd  in  32  memory read data, valid one cycle after mem_a is presented with mem_we=0

Behaviour:
- States: IDLE, READ, WAIT, WRITE, RESP.
- Reset, asynchronous: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0; all latched request fields cleared.
- req_ready=1 only in IDLE. Handshake = req_valid && req_ready. The request is latched that cycle; later input changes are ignored.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE transitions on handshake:
  - misaligned with MISALIGN_TRAP_EN -> RESP
  - word store -> WRITE
  - otherwise -> READ
- READ: mem_a=latched word address, mem_we=0 -> WAIT.
- WAIT: mem_rd is valid.
  - Load: extract lane by addr[1:0], extend, register into resp_rdata -> RESP.
  - Sub-word store: merge store data into the mem_rd lane, register as merged word -> WRITE.
- WRITE: mem_we=1, mem_a=word address, mem_wd = full store data (word store) or merged word -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
  - resp_err=1 only for a trapped misalignment; such a request asserts no mem_we and performs no read.
  - resp_rdata=0 for stores and errors.
- No back-pressure on resp. The pipeline must consume the pulse.
- Latency, handshake edge to resp_valid high: word store 2 cycles, load 3 cycles, sub-word store 4 cycles, trapped error 1 cycle.
- mem_we is high only in WRITE, decoded from the state register, so it is never asserted outside WRITE.
- Reset mid-operation: in-flight access is abandoned; no write issues after rst rises; no resp_valid for the aborted request.
- Byte lanes: lane k = bits [8k+7:8k] with k=addr[1:0]. A halfword uses lanes addr[1]*2 and addr[1]*2+1.
- Back-to-back: the next request can be accepted the cycle after RESP.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned requests complete through RESP with resp_err=1 and cause no memory access.
- Undefined: resp_err is tied 0. Misaligned addresses are force-aligned, with addr[0] cleared for half and addr[1:0] cleared for word, and the access proceeds normally.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding constants ST_IDLE..ST_RESP, 3-bit
- One combinational sub-module, lsu_lane_align, provides:
  - load extract/extend: mem_rd, offset, size, unsigned -> 32-bit result
  - store merge: old word, store data, offset, size -> merged word
- The FSM stays in lsu_mem_port.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> mem_we pulse at word 4 two cycles after handshake; load resp_rdata=0xDEADBEEF, 3 cycles after handshake.
- Word 4 = 0x11223344; SB addr 0x12, data 0x000000AA -> word 4 = 0x11AA3344; resp 4 cycles after handshake.
- Word 5 = 0x80FF7F01:
  - LB 0x17 -> 0xFFFFFF80
  - LBU 0x17 -> 0x00000080
  - LH 0x14 -> 0x00007F01
  - LHU 0x16 -> 0x000080FF
- SH addr 0x16, data 0x0000BEEF over word 5 = 0x80FF7F01 -> 0xBEEF7F01. Then SH 0x15:
  - trap on: resp_err=1 after 1 cycle, word 5 unchanged, mem_we never high.
  - trap off: write lands at 0x14, lower half.
- Assert rst in the READ cycle of an SB -> mem_we stays 0, no resp_valid; target word unchanged; req_ready=1 the cycle after rst falls.
- Hold req_valid high continuously with alternating LW/SW -> exactly one handshake per IDLE visit, req_ready low while busy, no request dropped or duplicated.
